pitch_sched: RTL

PITCH_SCHED -- requirements
Module: pitch_sched

---
 rtl/pitch_sched_if.sv | 33 +++
 rtl/pitch_sched.sv | 107 ++++++++++
 2 files changed

// File: rtl/pitch_sched_if.sv
// Signal bundle for pitch_sched: sample stream in/out, status strobes and the
// external pitch-RAM port.
interface pitch_sched_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              sample_valid;
  logic [DATA_W-1:0] data_in;
  logic [9:0]        step;
  logic              bypass;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [DATA_W-1:0] ram_data;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              busy;
  logic              splice;
  logic              overrun;

  modport master (
    output sample_valid, data_in, step, bypass, ram_q,
    input  ram_wren, ram_wraddr, ram_rdaddr, ram_data,
    input  data_out, out_valid, busy, splice, overrun
  );

  modport slave (
    input  sample_valid, data_in, step, bypass, ram_q,
    output ram_wren, ram_wraddr, ram_rdaddr, ram_data,
    output data_out, out_valid, busy, splice, overrun
  );
endinterface

// File: rtl/pitch_sched.sv
// Ring-buffer pitch shifter scheduler: writes each sample at wp, reads at the
// fractional pointer rp, and splices rp by half a buffer when it nears wp.
module pitch_sched #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2,
  parameter int GUARD  = 8
) (
  input  logic        Clk,
  input  logic        reset,
  pitch_sched_if.slave bus
);
  localparam int RPW = ADDR_W + 8;
  localparam int CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [ADDR_W:0]   G_LO = (ADDR_W+1)'(GUARD);
  localparam logic [ADDR_W:0]   G_HI = (ADDR_W+1)'((2**ADDR_W) - GUARD);
  localparam logic [ADDR_W-1:0] HALF = {1'b1, {(ADDR_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wp;
  logic [RPW-1:0]    rp;
  logic [CW-1:0]     cnt;
  logic              byp_l;
  logic [9:0]        step_l;

  logic [9:0]        step_c;
  logic [ADDR_W-1:0] wp_n;
  logic [RPW-1:0]    rp_n;
  logic [ADDR_W-1:0] d;
  logic              guard_hit;

  always_comb begin
    step_c = bus.step;
    if (bus.step < 10'h040)
      step_c = 10'h040;
    else if (bus.step > 10'h200)
      step_c = 10'h200;
    wp_n      = wp + 1'b1;
    rp_n      = rp + RPW'(step_l);
    d         = wp_n - rp_n[RPW-1:8];
    guard_hit = ({1'b0, d} < G_LO) || ({1'b0, d} > G_HI);
  end

  // Overrun must flag the offending strobe in its own cycle, so it is not registered.
  assign bus.overrun = bus.sample_valid & bus.busy;

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wp             <= '0;
      rp             <= {1'b1, {(RPW-1){1'b0}}};
      cnt            <= '0;
      byp_l          <= 1'b0;
      step_l         <= 10'h100;
      bus.ram_wren   <= 1'b0;
      bus.ram_wraddr <= '0;
      bus.ram_rdaddr <= '0;
      bus.ram_data   <= '0;
      bus.data_out   <= '0;
      bus.out_valid  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.splice     <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.splice    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            byp_l          <= bus.bypass;
            step_l         <= step_c;
            bus.ram_wren   <= 1'b1;
            bus.ram_wraddr <= wp;
            bus.ram_rdaddr <= rp[RPW-1:8];
            bus.ram_data   <= bus.data_in;
            bus.busy       <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          bus.ram_wren <= 1'b0;
          cnt          <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          if (cnt == CW'(RD_LAT - 1)) begin
            // ram_data still holds the accepted sample, so it doubles as the dry path.
            bus.data_out  <= byp_l ? bus.ram_data : bus.ram_q;
            bus.out_valid <= 1'b1;
            wp            <= wp_n;
            rp            <= guard_hit ? {rp_n[RPW-1:8] - HALF, rp_n[7:0]} : rp_n;
            bus.splice    <= guard_hit;
            state         <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
